inst_sequencer: RTL and testbench
=================================

# inst_sequencer

Sequences the acquisition, trigger-delay and readout phases of the chip from the one-shot instruction strobes (`inst_rst`, `inst_readout`, `inst_start`) and the `clk_enable` level that the SPI peripheral produces. It sits directly downstream of the SPI block and runs in the internal clock domain. It consumes the SPI-programmed `trigger_channel_mask` and `trig_delay` registers. It drives the core reset, the sampling enable and the per-channel readout strobes toward the analog/serializer side.

## Interface
- `RST_CYCLES`, default 16: cycles `core_rst` is held after a reset instruction; must be ≥ 1.
- `CH_READ_CYCLES`, default 32: cycles `rd_valid` is held per read channel; must be ≥ 1.
- `SYNC_STAGES`, default 2: synchronizer depth for the instruction strobes; must be ≥ 2.

Ports:
- `iclk` in 1: internal clock; the only clock of the block.
- `rst` in 1: asynchronous, active-high reset.
- `inst_rst` in 1: reset instruction strobe, asynchronous to `iclk`.
- `inst_readout` in 1: readout instruction strobe, asynchronous to `iclk`.
- `inst_start` in 1: start instruction strobe, asynchronous to `iclk`.
- `clk_enable` in 1: start-instruction level from SPI; quasi-static, synchronized internally with the same depth.
- `trigger_channel_mask` in 8: channel read-enable mask; bit n selects channel n.
- `trig_delay` in 8: post-trigger acquisition extension, in `iclk` cycles.
- `trigger` in 1: discriminator trigger, already synchronous to `iclk`.
- `core_rst` out 1: core reset, active-high.
- `acq_en` out 1: sampling enable.
- `stop_acq` out 1: one-cycle pulse when acquisition ends.
- `rd_ch` out 3: channel currently being read.
- `rd_load` out 1: one-cycle pulse on the first cycle of each channel read.
- `rd_valid` out 1: high while `rd_ch` is being read.
- `done` out 1: one-cycle pulse when a readout completes.
- `busy` out 1: high when the state is not IDLE.
- `cmd_err` out 1: one-cycle pulse when a command is rejected.

## Operation
- **Strobe conditioning:** each `inst_*` input passes through `SYNC_STAGES` flops, then a rising-edge detector. The result is a one-cycle `cmd_rst`, `cmd_rd` or `cmd_start`.
- **Command priority** when several arrive in the same cycle: `cmd_rst` > `cmd_rd` > `cmd_start`. The lower-priority commands in that cycle are dropped and `cmd_err` pulses.
- **States:** IDLE, RESET, RUN, DELAY, READOUT. All outputs are registered.
- **Any state + `cmd_rst`** → RESET, with the counter set to `RST_CYCLES`-1.
  - An in-progress readout is abandoned with no `done` pulse.
  - If `acq_en` was high, `stop_acq` is not pulsed.
- **RESET:** `core_rst`=1. Counter decrements each cycle; on 0 → IDLE.
- **IDLE + `cmd_start`:**
  - With synchronized `clk_enable`=1 → RUN.
  - Otherwise stay in IDLE and pulse `cmd_err`.
- **IDLE + `cmd_rd`:** capture `trigger_channel_mask` into `mask_q`.
  - If `mask_q`≠0 → READOUT.
  - If `mask_q`=0 → pulse `done`, stay in IDLE.
- **`cmd_rd` or `cmd_start` outside IDLE:** ignored; `cmd_err` pulses.
- **RUN:** `acq_en`=1.
  - `trigger`=1 → DELAY, with `cnt`←`trig_delay`.
  - Synchronized `clk_enable` falling to 0 → IDLE and pulse `stop_acq`. Trigger takes precedence if both occur in the same cycle.
- **DELAY:** `acq_en`=1; `clk_enable` and `trigger` are ignored.
  - If `cnt`=0 → IDLE and pulse `stop_acq`.
  - Otherwise `cnt`←`cnt`-1.
- **READOUT:**
  - Visits the set bits of `mask_q` in ascending index order.
  - Per channel: `rd_ch`=index, `rd_load` on its first cycle, `rd_valid`=1 for exactly `CH_READ_CYCLES` cycles.
  - Consecutive channels are back-to-back, with no gap cycle.
  - After the last set bit: `rd_valid`→0, `done` pulses, return to IDLE.
- **Counter widths:** 8-bit `cnt`; `$clog2` widths for the parameter-sized counters. No wrap-around is ever reachable.

## Timing
- **Reset values** while `rst`=1, applied asynchronously: state IDLE, all outputs 0, `rd_ch`=0, synchronizers and counters cleared.
- **Command latency:** `inst_*` rising edge to state change is `SYNC_STAGES`+1 `iclk` edges, ±1 for metastability.
- **Reset instruction:** `core_rst` is high for exactly `RST_CYCLES` cycles.
- **Trigger path:** with `trigger` sampled high at edge t:
  - DELAY is entered at t+1.
  - `acq_en` falls and `stop_acq` is high in the cycle after edge t+`trig_delay`+2.
  - With `trig_delay`=0, `acq_en` stays high for 2 cycles after the trigger cycle.
- **Readout:**
  - `rd_load` and `rd_valid` rise one edge after READOUT is entered.
  - `done` pulses in the cycle after the last `rd_valid` cycle.
  - Total readout length is popcount(`mask_q`)×`CH_READ_CYCLES`.
- **Re-triggering:** an instruction strobe held high for a long time produces only one command; the edge detector re-arms only after the synchronized level returns to 0.

## Test plan
- **Reset instruction:** pulse `inst_rst` with `RST_CYCLES`=16 → `core_rst` high for exactly 16 cycles, `busy` high for the same window, then IDLE.
- **Start and trigger:** `clk_enable`=1, pulse `inst_start`, `trig_delay`=5, assert `trigger` → `acq_en` falls 7 cycles after the trigger edge. `stop_acq` is a single pulse coincident with the fall.
- **Sparse readout:** `trigger_channel_mask`=8'b1000_0101, pulse `inst_readout` → `rd_ch` sequence 0, 2, 7. Three `rd_load` pulses, 96 `rd_valid` cycles, then one `done`.
- **Empty and rejected commands:**
  - `mask`=0 plus `inst_readout` → `done` within `SYNC_STAGES`+2 cycles, with no `rd_valid`.
  - `inst_start` with `clk_enable`=0 → `cmd_err` pulse, `acq_en` stays 0.
- **Abort:** `inst_rst` midway through the channel-2 read → `rd_valid` drops and RESET is entered, with no `done` pulse. Same check with `clk_enable` dropped in RUN → `stop_acq` pulse.
- **Priority and asynchronous reset:**
  - `inst_readout` and `inst_start` raised together → READOUT plus `cmd_err`.
  - `rst` asserted mid-DELAY → all outputs 0 immediately, with no clock edge.

Source files
------------

// File: rtl/inst_sequencer.sv
// inst_sequencer
//   Sequences the reset, acquisition, trigger-delay and readout phases of the
//   chip. Commands come from one-shot instruction strobes produced by the SPI
//   block. The strobes are asynchronous to iclk and are synchronized and
//   edge-detected here.
//
// Ports
//   iclk                  internal clock (only clock of the block)
//   rst                   asynchronous active-high reset
//   inst_rst              reset instruction strobe (async)
//   inst_readout          readout instruction strobe (async)
//   inst_start            start instruction strobe (async)
//   clk_enable            start-instruction level from SPI (quasi-static)
//   trigger_channel_mask  channel read-enable mask, bit n selects channel n
//   trig_delay            post-trigger acquisition extension in iclk cycles
//   trigger               discriminator trigger, synchronous to iclk
//   core_rst              core reset, high for RST_CYCLES cycles
//   acq_en                sampling enable
//   stop_acq              one-cycle pulse when acquisition ends
//   rd_ch                 channel currently being read
//   rd_load               one-cycle pulse on the first cycle of each channel read
//   rd_valid              high while rd_ch is being read
//   done                  one-cycle pulse when a readout completes
//   busy                  high whenever the sequencer is not idle
//   cmd_err               one-cycle pulse when a command is rejected
module inst_sequencer #(
    parameter int RST_CYCLES     = 16,
    parameter int CH_READ_CYCLES = 32,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       iclk,
    input  logic       rst,
    input  logic       inst_rst,
    input  logic       inst_readout,
    input  logic       inst_start,
    input  logic       clk_enable,
    input  logic [7:0] trigger_channel_mask,
    input  logic [7:0] trig_delay,
    input  logic       trigger,
    output logic       core_rst,
    output logic       acq_en,
    output logic       stop_acq,
    output logic [2:0] rd_ch,
    output logic       rd_load,
    output logic       rd_valid,
    output logic       done,
    output logic       busy,
    output logic       cmd_err
);

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int CCW = (CH_READ_CYCLES > 1) ? $clog2(CH_READ_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LOAD = RCW'(RST_CYCLES - 1);
    localparam logic [CCW-1:0] CH_LOAD  = CCW'(CH_READ_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DELAY,
        S_READOUT
    } state_t;

    // Index of the lowest set bit; the caller guarantees m != 0.
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Strobe synchronizers and edge detectors
    logic [SYNC_STAGES-1:0] sync_rst_q, sync_rd_q, sync_st_q, sync_ce_q;
    logic                   prev_rst_q, prev_rd_q, prev_st_q;
    logic                   trig_q;
    logic                   cmd_rst, cmd_rd, cmd_start, ce_s;

    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            sync_rst_q <= '0;
            sync_rd_q  <= '0;
            sync_st_q  <= '0;
            sync_ce_q  <= '0;
            prev_rst_q <= 1'b0;
            prev_rd_q  <= 1'b0;
            prev_st_q  <= 1'b0;
            trig_q     <= 1'b0;
        end else begin
            sync_rst_q <= {sync_rst_q[SYNC_STAGES-2:0], inst_rst};
            sync_rd_q  <= {sync_rd_q[SYNC_STAGES-2:0], inst_readout};
            sync_st_q  <= {sync_st_q[SYNC_STAGES-2:0], inst_start};
            sync_ce_q  <= {sync_ce_q[SYNC_STAGES-2:0], clk_enable};
            prev_rst_q <= sync_rst_q[SYNC_STAGES-1];
            prev_rd_q  <= sync_rd_q[SYNC_STAGES-1];
            prev_st_q  <= sync_st_q[SYNC_STAGES-1];
            // The trigger is registered once so that DELAY starts one edge
            // after the edge that samples it.
            trig_q     <= trigger;
        end
    end

    assign cmd_rst   = sync_rst_q[SYNC_STAGES-1] & ~prev_rst_q;
    assign cmd_rd    = sync_rd_q[SYNC_STAGES-1] & ~prev_rd_q;
    assign cmd_start = sync_st_q[SYNC_STAGES-1] & ~prev_st_q;
    assign ce_s      = sync_ce_q[SYNC_STAGES-1];

    // Sequencer state and registered outputs
    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic [CCW-1:0] ccnt_q, ccnt_d;
    logic [7:0]     mask_q, mask_d;
    logic           rd_active_q, rd_active_d;
    logic           core_rst_q, core_rst_d;
    logic           acq_en_q, acq_en_d;
    logic           stop_acq_q, stop_acq_d;
    logic [2:0]     rd_ch_q, rd_ch_d;
    logic           rd_load_q, rd_load_d;
    logic           rd_valid_q, rd_valid_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic           cmd_err_q, cmd_err_d;

    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            rcnt_q      <= '0;
            ccnt_q      <= '0;
            mask_q      <= 8'd0;
            rd_active_q <= 1'b0;
            core_rst_q  <= 1'b0;
            acq_en_q    <= 1'b0;
            stop_acq_q  <= 1'b0;
            rd_ch_q     <= 3'd0;
            rd_load_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            ccnt_q      <= ccnt_d;
            mask_q      <= mask_d;
            rd_active_q <= rd_active_d;
            core_rst_q  <= core_rst_d;
            acq_en_q    <= acq_en_d;
            stop_acq_q  <= stop_acq_d;
            rd_ch_q     <= rd_ch_d;
            rd_load_q   <= rd_load_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rcnt_d      = rcnt_q;
        ccnt_d      = ccnt_q;
        mask_d      = mask_q;
        rd_active_d = rd_active_q;
        rd_ch_d     = rd_ch_q;
        rd_valid_d  = rd_valid_q;
        rd_load_d   = 1'b0;
        stop_acq_d  = 1'b0;
        done_d      = 1'b0;
        cmd_err_d   = 1'b0;

        if (cmd_rst) begin
            // Reset overrides everything; a running readout or acquisition is
            // dropped silently.
            state_d     = S_RESET;
            rcnt_d      = RST_LOAD;
            rd_active_d = 1'b0;
            rd_valid_d  = 1'b0;
            cmd_err_d   = cmd_rd | cmd_start;
        end else begin
            // A start arriving together with a readout is always dropped.
            if (cmd_rd && cmd_start) cmd_err_d = 1'b1;
            if (state_q != S_IDLE && (cmd_rd || cmd_start)) cmd_err_d = 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (cmd_rd) begin
                        mask_d      = trigger_channel_mask;
                        rd_active_d = 1'b0;
                        if (trigger_channel_mask == 8'd0) done_d = 1'b1;
                        else state_d = S_READOUT;
                    end else if (cmd_start) begin
                        if (ce_s) state_d = S_RUN;
                        else cmd_err_d = 1'b1;
                    end
                end
                S_RESET: begin
                    if (rcnt_q == '0) state_d = S_IDLE;
                    else rcnt_d = rcnt_q - RCW'(1);
                end
                S_RUN: begin
                    if (trig_q) begin
                        state_d = S_DELAY;
                        cnt_d   = trig_delay;
                    end else if (!ce_s) begin
                        state_d    = S_IDLE;
                        stop_acq_d = 1'b1;
                    end
                end
                S_DELAY: begin
                    if (cnt_q == 8'd0) begin
                        state_d    = S_IDLE;
                        stop_acq_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                S_READOUT: begin
                    // mask_q holds the channels still to be read; each load
                    // consumes its lowest set bit.
                    if (!rd_active_q || ccnt_q == '0) begin
                        if (mask_q != 8'd0) begin
                            rd_ch_d     = lowest_set(mask_q);
                            mask_d      = mask_q & (mask_q - 8'd1);
                            rd_load_d   = 1'b1;
                            rd_valid_d  = 1'b1;
                            ccnt_d      = CH_LOAD;
                            rd_active_d = 1'b1;
                        end else begin
                            rd_valid_d  = 1'b0;
                            rd_active_d = 1'b0;
                            done_d      = 1'b1;
                            state_d     = S_IDLE;
                        end
                    end else begin
                        ccnt_d = ccnt_q - CCW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        core_rst_d = (state_d == S_RESET);
        acq_en_d   = (state_d == S_RUN) || (state_d == S_DELAY);
        busy_d     = (state_d != S_IDLE);
    end

    assign core_rst = core_rst_q;
    assign acq_en   = acq_en_q;
    assign stop_acq = stop_acq_q;
    assign rd_ch    = rd_ch_q;
    assign rd_load  = rd_load_q;
    assign rd_valid = rd_valid_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_inst_sequencer.sv
module tb_inst_sequencer;

    logic       iclk = 1'b0;
    logic       rst = 1'b0;
    logic       inst_rst = 1'b0;
    logic       inst_readout = 1'b0;
    logic       inst_start = 1'b0;
    logic       clk_enable = 1'b0;
    logic [7:0] trigger_channel_mask = 8'd0;
    logic [7:0] trig_delay = 8'd0;
    logic       trigger = 1'b0;
    logic       core_rst, acq_en, stop_acq, rd_load, rd_valid, done, busy, cmd_err;
    logic [2:0] rd_ch;

    int checks = 0;
    int errors = 0;

    // Scoreboard of expected rd_ch values, one per rd_load pulse.
    logic [2:0] exp_ch_q[$];

    int mon_busy = 0, mon_load = 0, mon_valid = 0, mon_done = 0;
    int mon_stop = 0, mon_err = 0, mon_acq = 0;

    inst_sequencer #(
        .RST_CYCLES    (16),
        .CH_READ_CYCLES(32),
        .SYNC_STAGES   (2)
    ) dut (
        .iclk                (iclk),
        .rst                 (rst),
        .inst_rst            (inst_rst),
        .inst_readout        (inst_readout),
        .inst_start          (inst_start),
        .clk_enable          (clk_enable),
        .trigger_channel_mask(trigger_channel_mask),
        .trig_delay          (trig_delay),
        .trigger             (trigger),
        .core_rst            (core_rst),
        .acq_en              (acq_en),
        .stop_acq            (stop_acq),
        .rd_ch               (rd_ch),
        .rd_load             (rd_load),
        .rd_valid            (rd_valid),
        .done                (done),
        .busy                (busy),
        .cmd_err             (cmd_err)
    );

    always #5 iclk = ~iclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge iclk);
    endtask

    always @(negedge iclk) begin
        if (!rst) begin
            if (busy) mon_busy++;
            if (rd_valid) mon_valid++;
            if (done) mon_done++;
            if (stop_acq) mon_stop++;
            if (cmd_err) mon_err++;
            if (acq_en) mon_acq++;
            if (rd_load) begin
                mon_load++;
                check("rd_load_with_valid", rd_valid, 1'b1);
                if (exp_ch_q.size() > 0) check("rd_ch_order", rd_ch, exp_ch_q.pop_front());
                else check("rd_load_unexpected", rd_load, 1'b0);
            end
        end
    end

    initial begin
        int n, gaps, b0, s0, e0, l0, v0, d0, a0;

        // Reset state
        #1 rst = 1'b1;
        tick(3);
        check("reset_outputs", {core_rst, acq_en, stop_acq, rd_ch, rd_load, rd_valid, done, busy, cmd_err}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Reset instruction: core_rst and busy high for 16 cycles
        b0 = mon_busy;
        inst_rst = 1'b1;
        n = 0;
        while (!core_rst && n < 10) begin tick(1); n++; end
        check("rst_core_rst_seen", core_rst, 1'b1);
        inst_rst = 1'b0;
        n = 0;
        while (core_rst && n < 100) begin n++; tick(1); end
        check("rst_core_rst_len", n, 16);
        check("rst_busy_len", mon_busy - b0, 16);
        check("rst_back_idle", busy, 1'b0);

        // Start and trigger with trig_delay = 5
        clk_enable = 1'b1;
        trig_delay = 8'd5;
        tick(4);
        inst_start = 1'b1;
        n = 0;
        while (!acq_en && n < 10) begin tick(1); n++; end
        check("start_acq_en", acq_en, 1'b1);
        inst_start = 1'b0;
        tick(3);
        s0 = mon_stop;
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        n = 0;
        while (acq_en && n < 50) begin n++; tick(1); end
        check("trig_acq_high_cycles", n, 7);
        check("trig_stop_at_fall", stop_acq, 1'b1);
        tick(2);
        check("trig_stop_single", mon_stop - s0, 1);

        // clk_enable dropped in RUN
        inst_start = 1'b1;
        n = 0;
        while (!acq_en && n < 10) begin tick(1); n++; end
        check("run2_acq_en", acq_en, 1'b1);
        inst_start = 1'b0;
        tick(3);
        s0 = mon_stop;
        clk_enable = 1'b0;
        n = 0;
        while (acq_en && n < 10) begin tick(1); n++; end
        check("ce_drop_stop", stop_acq, 1'b1);
        tick(2);
        check("ce_drop_stop_count", mon_stop - s0, 1);

        // Start rejected with clk_enable = 0
        e0 = mon_err;
        a0 = mon_acq;
        inst_start = 1'b1;
        tick(4);
        inst_start = 1'b0;
        tick(4);
        check("start_rej_err", mon_err - e0, 1);
        check("start_rej_no_acq", mon_acq - a0, 0);

        // Sparse readout 0, 2, 7
        exp_ch_q.push_back(3'd0);
        exp_ch_q.push_back(3'd2);
        exp_ch_q.push_back(3'd7);
        trigger_channel_mask = 8'b1000_0101;
        l0 = mon_load;
        d0 = mon_done;
        inst_readout = 1'b1;
        n = 0;
        while (!rd_valid && n < 10) begin tick(1); n++; end
        check("rd_started", rd_valid, 1'b1);
        inst_readout = 1'b0;
        n = 0;
        gaps = 0;
        while (!done && (n + gaps) < 400) begin
            if (rd_valid) n++; else gaps++;
            tick(1);
        end
        check("rd_valid_cycles", n, 96);
        check("rd_no_gaps", gaps, 0);
        check("rd_valid_low_at_done", rd_valid, 1'b0);
        tick(3);
        check("rd_load_count", mon_load - l0, 3);
        check("rd_done_count", mon_done - d0, 1);
        check("rd_scoreboard_empty", exp_ch_q.size(), 0);
        check("rd_idle_after", busy, 1'b0);

        // Empty readout; strobe held long produces one command
        trigger_channel_mask = 8'd0;
        d0 = mon_done;
        v0 = mon_valid;
        inst_readout = 1'b1;
        n = 0;
        while (!done && n < 10) begin tick(1); n++; end
        check("empty_done_latency_ok", (n >= 1 && n <= 4), 1'b1);
        tick(8);
        inst_readout = 1'b0;
        tick(4);
        check("empty_done_once", mon_done - d0, 1);
        check("empty_no_valid", mon_valid - v0, 0);

        // Readout and start together
        clk_enable = 1'b1;
        tick(4);
        exp_ch_q.push_back(3'd1);
        trigger_channel_mask = 8'b0000_0010;
        e0 = mon_err;
        d0 = mon_done;
        v0 = mon_valid;
        a0 = mon_acq;
        inst_readout = 1'b1;
        inst_start = 1'b1;
        n = 0;
        while (!done && n < 200) begin tick(1); n++; end
        check("prio_done", done, 1'b1);
        inst_readout = 1'b0;
        inst_start = 1'b0;
        tick(3);
        check("prio_err", mon_err - e0, 1);
        check("prio_valid_cycles", mon_valid - v0, 32);
        check("prio_no_acq", mon_acq - a0, 0);
        check("prio_scoreboard_empty", exp_ch_q.size(), 0);

        // Abort midway through the channel-2 read
        exp_ch_q.push_back(3'd0);
        exp_ch_q.push_back(3'd2);
        trigger_channel_mask = 8'b1000_0101;
        d0 = mon_done;
        l0 = mon_load;
        inst_readout = 1'b1;
        n = 0;
        while (!(rd_load && rd_ch == 3'd2) && n < 200) begin tick(1); n++; end
        check("abort_ch2_reached", (n < 200), 1'b1);
        inst_readout = 1'b0;
        tick(10);
        inst_rst = 1'b1;
        n = 0;
        while (!core_rst && n < 10) begin tick(1); n++; end
        check("abort_reset_entered", core_rst, 1'b1);
        check("abort_valid_dropped", rd_valid, 1'b0);
        inst_rst = 1'b0;
        n = 0;
        while (core_rst && n < 40) begin tick(1); n++; end
        tick(2);
        check("abort_no_done", mon_done - d0, 0);
        check("abort_load_count", mon_load - l0, 2);
        check("abort_scoreboard_empty", exp_ch_q.size(), 0);

        // Asynchronous reset in DELAY
        trig_delay = 8'd200;
        inst_start = 1'b1;
        n = 0;
        while (!acq_en && n < 10) begin tick(1); n++; end
        inst_start = 1'b0;
        tick(2);
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        tick(5);
        check("delay_acq_en", acq_en, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outputs", {core_rst, acq_en, stop_acq, rd_ch, rd_load, rd_valid, done, busy, cmd_err}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);
        check("post_rst_idle", {acq_en, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
